// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame checker.
//   rx_state_t      : frame position of the receiver
//   PAR_EVEN/PAR_ODD: encodings of the par_typ input
//   DATA_WIDTH_MIN/MAX, CNT_WIDTH_MIN: legal parameter ranges
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int CNT_WIDTH_MIN  = 2;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter.
//   clk   : system clock
//   rst   : synchronous active-low reset
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over inc
//   count : current value, sticks at all-ones
module uart_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker. Consumes one majority-voted bit per bit_valid
// strobe, tracks the position within the frame, checks start, optional
// parity and one or two stop bits, and delivers the received word together
// with registered error flags and saturating error counters.
//   clk, rst              : clock, synchronous active-low reset
//   frame_start           : start-edge pulse, accepted only when idle
//   bit_valid, sampled_bit: sampled line bit and its strobe
//   par_en, par_typ, stop2: frame format, captured at frame acceptance
//   clr_cnt               : clear both error counters
//   busy                  : frame in progress
//   data_out              : last received word (first line bit in LSB)
//   frame_done, data_valid: end-of-frame pulse and clean-frame pulse
//   par_err, stop_err     : error flags of the last completed frame
//   start_err             : false-start pulse
//   par_err_cnt, stop_err_cnt : saturating error counters
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic                  clr_cnt,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  start_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

    generate
        if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
            $error("uart_rx_frame_check: DATA_WIDTH out of range");
        end
        if (CNT_WIDTH < CNT_WIDTH_MIN) begin : g_bad_cnt_width
            $error("uart_rx_frame_check: CNT_WIDTH out of range");
        end
    endgenerate

    rx_state_t              state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   run_par;
    logic                   cfg_par_en;
    logic                   cfg_par_typ;
    logic                   cfg_stop2;
    logic                   par_err_n;
    logic                   stop_err_n;

    logic                   finish;
    logic                   fin_par_err;
    logic                   fin_stop_err;

    // The last stop bit's own sample is folded in combinationally so the
    // flags, the done pulse and the counters all see the full frame verdict
    // at the same clock edge.
    always_comb begin
        finish       = bit_valid &&
                       (((state == ST_STOP1) && !cfg_stop2) || (state == ST_STOP2));
        fin_stop_err = stop_err_n | ~sampled_bit;
        fin_par_err  = cfg_par_en & par_err_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            run_par     <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= PAR_EVEN;
            cfg_stop2   <= 1'b0;
            par_err_n   <= 1'b0;
            stop_err_n  <= 1'b0;
            busy        <= 1'b0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            data_valid <= 1'b0;
            start_err  <= 1'b0;

            case (state)
                // bit_valid is deliberately ignored here, even in the
                // acceptance cycle.
                ST_IDLE: begin
                    if (frame_start) begin
                        cfg_par_en  <= par_en;
                        cfg_par_typ <= par_typ;
                        cfg_stop2   <= stop2;
                        bit_cnt     <= '0;
                        run_par     <= 1'b0;
                        par_err_n   <= 1'b0;
                        stop_err_n  <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_valid) begin
                        if (sampled_bit) begin
                            start_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                // Right shift with new bits entering at the MSB leaves the
                // first line bit in the LSB once the word is complete.
                ST_DATA: begin
                    if (bit_valid) begin
                        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        run_par <= run_par ^ sampled_bit;
                        bit_cnt <= bit_cnt + BIT_ONE;
                        if (bit_cnt == LAST_BIT) begin
                            state <= cfg_par_en ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        par_err_n <= sampled_bit != (run_par ^ cfg_par_typ);
                        state     <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (bit_valid) begin
                        stop_err_n <= stop_err_n | ~sampled_bit;
                        if (cfg_stop2) begin
                            state <= ST_STOP2;
                        end
                    end
                end
                ST_STOP2: begin
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            if (finish) begin
                data_out   <= shreg;
                par_err    <= fin_par_err;
                stop_err   <= fin_stop_err;
                frame_done <= 1'b1;
                data_valid <= ~(fin_par_err | fin_stop_err);
                busy       <= 1'b0;
                state      <= ST_IDLE;
            end
        end
    end

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (finish & fin_par_err),
        .clr   (clr_cnt),
        .count (par_err_cnt)
    );

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (finish & fin_stop_err),
        .clr   (clr_cnt),
        .count (stop_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Testbench for uart_rx_frame_check. Two instances are exercised one at a
// time: unit 0 is 8 data bits with 2-bit counters, unit 1 is 7 data bits
// with 4-bit counters. A frame-level model predicts every output and is
// compared on each falling edge; literal expectations pin the model.
module tb_uart_rx_frame_check;

    localparam int DW0 = 8;
    localparam int CW0 = 2;
    localparam int DW1 = 7;
    localparam int CW1 = 4;

    logic clk = 1'b0;
    logic rst;

    logic frame_start [2];
    logic bit_valid   [2];
    logic sampled_bit [2];
    logic par_en      [2];
    logic par_typ     [2];
    logic stop2       [2];
    logic clr_cnt     [2];

    logic busy        [2];
    logic frame_done  [2];
    logic data_valid  [2];
    logic par_err     [2];
    logic stop_err    [2];
    logic start_err   [2];
    logic [8:0] data_out [2];
    logic [3:0] par_cnt  [2];
    logic [3:0] stop_cnt [2];

    logic [DW0-1:0] d0;
    logic [DW1-1:0] d1;
    logic [CW0-1:0] pc0, sc0;
    logic [CW1-1:0] pc1, sc1;

    assign data_out[0] = {1'b0, d0};
    assign data_out[1] = {2'b0, d1};
    assign par_cnt[0]  = {2'b0, pc0};
    assign stop_cnt[0] = {2'b0, sc0};
    assign par_cnt[1]  = pc1;
    assign stop_cnt[1] = sc1;

    always #5 clk = ~clk;

    uart_rx_frame_check #(.DATA_WIDTH(DW0), .CNT_WIDTH(CW0)) dut0 (
        .clk(clk), .rst(rst),
        .frame_start(frame_start[0]), .bit_valid(bit_valid[0]), .sampled_bit(sampled_bit[0]),
        .par_en(par_en[0]), .par_typ(par_typ[0]), .stop2(stop2[0]), .clr_cnt(clr_cnt[0]),
        .busy(busy[0]), .data_out(d0), .frame_done(frame_done[0]), .data_valid(data_valid[0]),
        .par_err(par_err[0]), .stop_err(stop_err[0]), .start_err(start_err[0]),
        .par_err_cnt(pc0), .stop_err_cnt(sc0)
    );

    uart_rx_frame_check #(.DATA_WIDTH(DW1), .CNT_WIDTH(CW1)) dut1 (
        .clk(clk), .rst(rst),
        .frame_start(frame_start[1]), .bit_valid(bit_valid[1]), .sampled_bit(sampled_bit[1]),
        .par_en(par_en[1]), .par_typ(par_typ[1]), .stop2(stop2[1]), .clr_cnt(clr_cnt[1]),
        .busy(busy[1]), .data_out(d1), .frame_done(frame_done[1]), .data_valid(data_valid[1]),
        .par_err(par_err[1]), .stop_err(stop_err[1]), .start_err(start_err[1]),
        .par_err_cnt(pc1), .stop_err_cnt(sc1)
    );

    // Model of what each unit must show after the most recent rising edge.
    logic       exp_busy      [2];
    logic       exp_done      [2];
    logic       exp_valid     [2];
    logic       exp_perr      [2];
    logic       exp_serr      [2];
    logic       exp_start_err [2];
    logic [8:0] exp_data      [2];
    int         exp_pcnt      [2];
    int         exp_scnt      [2];

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output of both units against the model on each cycle.
    always @(negedge clk) begin
        if (check_en) begin
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("u%0d_busy", u),       32'(busy[u]),       32'(exp_busy[u]));
                checkOutput($sformatf("u%0d_frame_done", u), 32'(frame_done[u]), 32'(exp_done[u]));
                checkOutput($sformatf("u%0d_data_valid", u), 32'(data_valid[u]), 32'(exp_valid[u]));
                checkOutput($sformatf("u%0d_par_err", u),    32'(par_err[u]),    32'(exp_perr[u]));
                checkOutput($sformatf("u%0d_stop_err", u),   32'(stop_err[u]),   32'(exp_serr[u]));
                checkOutput($sformatf("u%0d_start_err", u),  32'(start_err[u]),  32'(exp_start_err[u]));
                checkOutput($sformatf("u%0d_data_out", u),   32'(data_out[u]),   32'(exp_data[u]));
                checkOutput($sformatf("u%0d_par_cnt", u),    32'(par_cnt[u]),    exp_pcnt[u]);
                checkOutput($sformatf("u%0d_stop_cnt", u),   32'(stop_cnt[u]),   exp_scnt[u]);
            end
        end
    end

    task automatic resetModel();
        for (int u = 0; u < 2; u++) begin
            exp_busy[u] = 1'b0;  exp_done[u] = 1'b0;  exp_valid[u] = 1'b0;
            exp_perr[u] = 1'b0;  exp_serr[u] = 1'b0;  exp_start_err[u] = 1'b0;
            exp_data[u] = '0;    exp_pcnt[u] = 0;     exp_scnt[u] = 0;
        end
    endtask

    // Advance one clock; single-cycle pulses expire unless re-armed by the caller.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            exp_done[u] = 1'b0;
            exp_valid[u] = 1'b0;
            exp_start_err[u] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int u, input logic fs, input logic bv, input logic sb);
        frame_start[u] = fs;
        bit_valid[u]   = bv;
        sampled_bit[u] = sb;
        tick();
        frame_start[u] = 1'b0;
        bit_valid[u]   = 1'b0;
    endtask

    // Idle cycle between bits: a frame_start here must be ignored while busy.
    task automatic gap(input int u);
        applyStimulus(u, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic sendFrame(input int u, input logic [8:0] data, input logic pe, input logic pt,
                             input logic s2, input logic start_bit, input logic par_bit,
                             input logic sb1, input logic sb2, input logic clr_end, input int abort_at);
        int         dw;
        int         cmax;
        logic [8:0] word;
        logic       perr;
        logic       serr;
        dw   = (u == 0) ? DW0 : DW1;
        cmax = (u == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
        word = data & ((9'd1 << dw) - 9'd1);

        par_en[u] = pe; par_typ[u] = pt; stop2[u] = s2;
        applyStimulus(u, 1'b1, 1'b1, 1'b1);
        exp_busy[u] = 1'b1;
        par_en[u] = ~pe; par_typ[u] = ~pt; stop2[u] = ~s2;

        gap(u);
        applyStimulus(u, 1'b0, 1'b1, start_bit);
        if (start_bit) begin
            exp_start_err[u] = 1'b1;
            exp_busy[u] = 1'b0;
            return;
        end

        for (int i = 0; i < dw; i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                tick();
                resetModel();
                rst = 1'b1;
                return;
            end
            gap(u);
            applyStimulus(u, 1'b0, 1'b1, word[i]);
        end

        if (pe) begin
            gap(u);
            applyStimulus(u, 1'b0, 1'b1, par_bit);
        end
        if (s2) begin
            gap(u);
            applyStimulus(u, 1'b0, 1'b1, sb1);
        end
        gap(u);
        if (clr_end) clr_cnt[u] = 1'b1;
        applyStimulus(u, 1'b0, 1'b1, s2 ? sb2 : sb1);

        perr = pe && (par_bit != ((^word) ^ pt));
        serr = !sb1 || (s2 && !sb2);
        exp_busy[u]  = 1'b0;
        exp_done[u]  = 1'b1;
        exp_valid[u] = !(perr || serr);
        exp_perr[u]  = perr;
        exp_serr[u]  = serr;
        exp_data[u]  = word;
        if (clr_end) begin
            exp_pcnt[u] = 0;
            exp_scnt[u] = 0;
            tick();
            clr_cnt[u] = 1'b0;
        end else begin
            if (perr && exp_pcnt[u] < cmax) exp_pcnt[u]++;
            if (serr && exp_scnt[u] < cmax) exp_scnt[u]++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            frame_start[u] = 1'b0; bit_valid[u] = 1'b0; sampled_bit[u] = 1'b1;
            par_en[u] = 1'b0; par_typ[u] = 1'b0; stop2[u] = 1'b0; clr_cnt[u] = 1'b0;
        end
        rst = 1'b0;
        resetModel();
        tick();
        tick();
        check_en = 1'b1;
        rst = 1'b1;
        tick();
        checkOutput("reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("reset_data", 32'(data_out[0]), 32'd0);

        // 8N1 0xA5
        sendFrame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("a5_data", 32'(data_out[0]), 32'h0A5);
        checkOutput("a5_done", 32'(frame_done[0]), 32'd1);
        checkOutput("a5_valid", 32'(data_valid[0]), 32'd1);
        checkOutput("a5_cnt", 32'(stop_cnt[0]) + 32'(par_cnt[0]), 32'd0);

        // 8E1 0x03 with wrong then right parity bit
        sendFrame(0, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("e1_par_err", 32'(par_err[0]), 32'd1);
        checkOutput("e1_valid", 32'(data_valid[0]), 32'd0);
        checkOutput("e1_par_cnt", 32'(par_cnt[0]), 32'd1);
        sendFrame(0, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("e1ok_par_err", 32'(par_err[0]), 32'd0);
        checkOutput("e1ok_valid", 32'(data_valid[0]), 32'd1);

        // 7O2 0x41 with stop bits 1,0
        sendFrame(1, 9'h041, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        checkOutput("o2_stop_err", 32'(stop_err[1]), 32'd1);
        checkOutput("o2_stop_cnt", 32'(stop_cnt[1]), 32'd1);
        checkOutput("o2_data", 32'(data_out[1]), 32'h041);
        checkOutput("o2_par_err", 32'(par_err[1]), 32'd0);

        // False start, then a clean frame
        sendFrame(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("fs_start_err", 32'(start_err[0]), 32'd1);
        checkOutput("fs_done", 32'(frame_done[0]), 32'd0);
        tick();
        checkOutput("fs_busy_after", 32'(busy[0]), 32'd0);
        checkOutput("fs_pulse_len", 32'(start_err[0]), 32'd0);
        sendFrame(0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("fs_next_data", 32'(data_out[0]), 32'h03C);

        // Stop-error saturation at 3, then clear on the fifth error
        for (int k = 0; k < 4; k++) begin
            sendFrame(0, 9'(k * 37 + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        end
        checkOutput("sat_stop_cnt", 32'(stop_cnt[0]), 32'd3);
        sendFrame(0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        checkOutput("clr_stop_cnt", 32'(stop_cnt[0]), 32'd0);
        checkOutput("clr_par_cnt", 32'(par_cnt[0]), 32'd0);

        // Reset mid-DATA, then clean frames on both units
        sendFrame(0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_data1", 32'(data_out[1]), 32'd0);
        sendFrame(0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("post_rst_data", 32'(data_out[0]), 32'h05A);
        checkOutput("post_rst_valid", 32'(data_valid[0]), 32'd1);
        sendFrame(1, 9'h05A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("u1_5a_data", 32'(data_out[1]), 32'h05A);
        checkOutput("u1_5a_valid", 32'(data_valid[1]), 32'd1);

        tick();
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
